fma_dot_pipe: RTL and testbench
===============================

Name: fma_dot_pipe

Overview:
Pipelined, parametrised successor to the scalar fused multiply-add unit. It accepts LANES operand pairs per beat and accumulates a dot product over a programmable number of beats. Per-product scaling has optional round-half-up, and the final result has optional saturation plus an overflow flag. It sits between the matrix processor's operand fetch and its writeback stage. Valid/ready handshakes on both sides let either neighbour stall it.

Parameters:
WIDTH, 32, operand/result width (signed two's complement)
LANES, 4, parallel multipliers per beat (power of two, >=1)
CNT_W, 8, width of the beat-count field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
a  in  LANES*WIDTH  lane operands A, lane i at bits [i*WIDTH +: WIDTH]
b  in  LANES*WIDTH  lane operands B, same packing
scale  in  $clog2(WIDTH)  unsigned right-shift applied to each product
seed  in  WIDTH  signed initial accumulator value
len  in  CNT_W  beats in this vector; 0 is treated as 1
round_en  in  1  round-half-up before shifting
sat_en  in  1  1 = saturate result, 0 = wrap
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  signed dot-product result
overflow  out  1  wide sum exceeded the signed WIDTH range

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset clears all pipeline valids, the counter and the state to IDLE. It also drives out_valid=0, result=0, overflow=0 and in_ready=0 during reset; in_ready=1 on the first cycle after reset.
- A beat is accepted on a rising edge where in_valid && in_ready are both high.
- States:
  - IDLE: in_ready=1. An accepted beat is the first of a vector. It latches len, scale, round_en, sat_en and seed; these are ignored on later beats. The beat counter loads max(len,1)-1. If the counter value is 0 the state moves to DRAIN, else to ACCUM.
  - ACCUM: in_ready=1. Each accepted beat decrements the counter. Acceptance at counter 1 is the last beat and moves the state to DRAIN. Gaps in in_valid are allowed and have no effect.
  - DRAIN: in_ready=0. Waits for the last beat to reach the output register, then moves to OUT.
  - OUT: in_ready=0, out_valid=1, and result/overflow are held stable. Handshake out_valid && out_ready moves the state to IDLE, and in_ready=1 on the next cycle.
- Pipeline, with E0 as the edge that accepts a beat:
  - E0: LANES full 2*WIDTH signed products are registered.
  - E1: each product p is handled as follows. If round_en && scale>0, p += 1<<(scale-1). Then p >>>= scale (arithmetic). The lane sum is registered at 2*WIDTH+$clog2(LANES) bits; no truncation.
  - E2: the accumulator, 2*WIDTH+$clog2(LANES)+CNT_W bits, updates. First beat: acc = sign-extended seed + lane sum. Otherwise acc += lane sum.
  - E3, last beat only: result register loads.
    - overflow = 1 if acc > 2^(WIDTH-1)-1 or acc < -2^(WIDTH-1), else 0.
    - If sat_en: result clamps to those limits. Otherwise result = acc[WIDTH-1:0].
  - out_valid is high in the cycle after E3, i.e. a fixed 3-edge latency from last-beat acceptance.
- One vector is in flight at a time; no beats are accepted from last-beat acceptance until the result handshake.
- Intermediate products and sums never wrap; only the final WIDTH conversion can saturate or wrap.
- Simultaneous rst and handshake: rst wins and the result is discarded.
- Reset mid-vector: partial accumulation is discarded, with no spurious out_valid.
- out_ready asserted while out_valid=0 is ignored.

Test Plan:
WIDTH=16, LANES=2 throughout.
1. Single beat. len=1, a={3,4}, b={5,6}, scale=0, seed=10 -> result=49, overflow=0, out_valid exactly 3 edges after acceptance.
2. Rounding. len=1, a={3,0}, b={1,0}, scale=1, seed=0:
   - round_en=0 -> 1; round_en=1 -> 2.
   - With a={-3,0}: round_en=0 -> -2; round_en=1 -> -1.
3. Saturation. len=4, every beat a={16384,16384}, b={4,4}, scale=0, seed=0 (wide sum 524288):
   - sat_en=1 -> result=32767, overflow=1.
   - sat_en=0 -> result=0, overflow=1.
4. Backpressure. Run vector 1 with out_ready=0 for 5 cycles -> result/out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one handshake, in_ready=1 next cycle.
5. Gapped input. len=3, beats a={1,2}, b={1,1} with 2 idle cycles between beats, seed=-5 -> result=4, identical to the contiguous run.
6. Reset mid-vector. Accept 2 of 4 beats, pulse rst -> out_valid stays 0, in_ready=1 after reset; the next vector (scenario 1) gives 49.

Source files
------------

// File: rtl/fma_dot_pipe.sv
// Pipelined LANES-wide multiply-accumulate dot-product unit.
// Scales each product, accumulates over len beats, saturates or wraps.
module fma_dot_pipe #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*WIDTH-1:0]     a,
  input  logic [LANES*WIDTH-1:0]     b,
  input  logic [$clog2(WIDTH)-1:0]   scale,
  input  logic [WIDTH-1:0]           seed,
  input  logic [CNT_W-1:0]           len,
  input  logic                       round_en,
  input  logic                       sat_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       overflow
);

  localparam int LG  = $clog2(LANES);
  localparam int SCW = $clog2(WIDTH);
  localparam int PW  = 2 * WIDTH;
  localparam int SW  = PW + LG;
  localparam int AW  = SW + CNT_W;

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  localparam logic [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic take, is_last;

  logic [SCW-1:0]   scale_q;
  logic             round_q, sat_q;
  logic [WIDTH-1:0] seed_q;

  logic signed [WIDTH-1:0] a_l [LANES];
  logic signed [WIDTH-1:0] b_l [LANES];
  logic signed [PW-1:0]    prod_q [LANES];
  logic signed [SW-1:0]    lsum, lsum_q, rnd, t;
  logic signed [AW-1:0]    acc_q;
  logic                    v0, v1, v2;
  logic                    first0, first1, last0, last1, last2;
  logic [WIDTH-1:0]        result_q;
  logic                    ov_q, ov;

  assign in_ready  = !rst && (state_q == IDLE || state_q == ACCUM);
  assign out_valid = !rst && (state_q == OUT);
  assign result    = rst ? '0 : result_q;
  assign overflow  = rst ? 1'b0 : ov_q;
  assign take      = in_valid && in_ready;
  assign is_last   = (state_q == IDLE && len <= CNT_W'(1)) ||
                     (state_q == ACCUM && cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: collect beats, drain pipe, hold result
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (take) state_d = is_last ? DRAIN : ACCUM;
      ACCUM: if (take && is_last) state_d = DRAIN;
      DRAIN: if (v2 && last2) state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counter and per-vector configuration latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      scale_q <= '0;
      round_q <= 1'b0;
      sat_q   <= 1'b0;
      seed_q  <= '0;
    end else if (take) begin
      if (state_q == IDLE) begin
        cnt_q   <= (len == '0) ? '0 : len - CNT_W'(1);
        scale_q <= scale;
        round_q <= round_en;
        sat_q   <= sat_en;
        seed_q  <= seed;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Unpack lane operands
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_l[i] = a[i*WIDTH +: WIDTH];
      b_l[i] = b[i*WIDTH +: WIDTH];
    end
  end

  // E0: full-width lane products
  always_ff @(posedge clk) begin
    if (rst) begin
      v0     <= 1'b0;
      first0 <= 1'b0;
      last0  <= 1'b0;
    end else begin
      v0     <= take;
      first0 <= take && state_q == IDLE;
      last0  <= take && is_last;
    end
    if (take)
      for (int i = 0; i < LANES; i++)
        prod_q[i] <= PW'(a_l[i]) * PW'(b_l[i]);
  end

  // Round, arithmetic shift and sum the lanes
  always_comb begin
    rnd  = '0;
    if (round_q && scale_q != '0)
      rnd = SW'(1) << (scale_q - SCW'(1));
    lsum = '0;
    t    = '0;
    for (int i = 0; i < LANES; i++) begin
      t    = SW'(prod_q[i]);
      t    = (t + rnd) >>> scale_q;
      lsum = lsum + t;
    end
  end

  // E1: register lane sum
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else begin
      v1     <= v0;
      first1 <= v0 && first0;
      last1  <= v0 && last0;
    end
    if (v0) lsum_q <= lsum;
  end

  // E2: accumulate, seeding on the first beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      acc_q <= '0;
    end else begin
      v2    <= v1;
      last2 <= v1 && last1;
      if (v1) begin
        if (first1)
          acc_q <= AW'($signed(seed_q)) + AW'(lsum_q);
        else
          acc_q <= acc_q + AW'(lsum_q);
      end
    end
  end

  assign ov = (acc_q > MAXV) || (acc_q < MINV);

  // E3: narrow to WIDTH with saturation or wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      ov_q     <= 1'b0;
    end else if (v2 && last2) begin
      ov_q <= ov;
      if (sat_q && ov)
        result_q <= acc_q[AW-1] ? MINW : MAXW;
      else
        result_q <= acc_q[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fma_dot_pipe.sv
// Directed self-checking bench for fma_dot_pipe.
// WIDTH=16, LANES=2 with hand-computed expectations.
module tb_fma_dot_pipe;

  localparam int W = 16;
  localparam int L = 2;
  localparam int C = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [L*W-1:0]       a = '0;
  logic [L*W-1:0]       b = '0;
  logic [3:0]           scale = '0;
  logic [W-1:0]         seed = '0;
  logic [C-1:0]         len = '0;
  logic                 round_en = 1'b0;
  logic                 sat_en = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [W-1:0]         result;
  logic                 overflow;

  int passed = 0;
  int total  = 0;

  fma_dot_pipe #(.WIDTH(W), .LANES(L), .CNT_W(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .scale(scale), .seed(seed), .len(len),
    .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic beat(
    input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
    input logic signed [W-1:0] b0, input logic signed [W-1:0] b1,
    input int ln, input int sc, input bit rd, input bit st,
    input logic signed [W-1:0] sd
  );
    int n;
    @(negedge clk);
    a = {a1, a0};
    b = {b1, b0};
    len = C'(ln);
    scale = 4'(sc);
    round_en = rd;
    sat_en = st;
    seed = sd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) $display("FAIL beat_accept timeout in_ready=%b required 1", in_ready);
    else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic handshake(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_hs out_valid=%b in_ready=%b required 0/1", nm, out_valid, in_ready);
    else passed++;
  endtask

  task automatic check_res(
    input string nm, input int lat, input int exp_lat,
    input logic [W-1:0] er, input logic eo
  );
    total++;
    if (lat !== exp_lat)
      $display("FAIL %s_latency got %0d required %0d", nm, lat, exp_lat);
    else passed++;
    total++;
    if (result !== er)
      $display("FAIL %s_result got %0d required %0d", nm, $signed(result), $signed(er));
    else passed++;
    total++;
    if (overflow !== eo)
      $display("FAIL %s_overflow got %b required %b", nm, overflow, eo);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0)
      $display("FAIL reset_outputs rdy=%b ov=%b res=%0d of=%b required 0/0/0/0",
               in_ready, out_valid, result, overflow);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_single(input string nm);
    int lat;
    beat(3, 4, 5, 6, 1, 0, 0, 0, 10);
    wait_out(lat);
    check_res(nm, lat, 3, 16'd49, 1'b0);
    handshake(nm);
  endtask

  task automatic test_rounding;
    int lat;
    logic signed [W-1:0] er [4] = '{16'sd1, 16'sd2, -16'sd2, -16'sd1};
    logic signed [W-1:0] av [4] = '{16'sd3, 16'sd3, -16'sd3, -16'sd3};
    for (int k = 0; k < 4; k++) begin
      beat(av[k], 0, 1, 0, 1, 1, k[0], 0, 0);
      wait_out(lat);
      check_res($sformatf("round%0d", k), lat, 3, er[k], 1'b0);
      handshake($sformatf("round%0d", k));
    end
  endtask

  task automatic test_saturation;
    int lat;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        beat(16384, 16384, 4, 4, 4, 0, 0, k == 0, 0);
      wait_out(lat);
      check_res(k == 0 ? "sat_on" : "sat_off", lat, 3,
                k == 0 ? 16'd32767 : 16'd0, 1'b1);
      handshake(k == 0 ? "sat_on" : "sat_off");
    end
  endtask

  task automatic test_backpressure;
    int lat;
    beat(3, 4, 5, 6, 1, 0, 0, 0, 10);
    wait_out(lat);
    check_res("bp", lat, 3, 16'd49, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = {16'd7, 16'd9};
      b = {16'd2, 16'd2};
      len = 1;
      in_valid = k[0];
      total++;
      if (out_valid !== 1'b1 || result !== 16'd49 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d out_valid=%b result=%0d in_ready=%b required 1/49/0",
                 k, out_valid, result, in_ready);
      else passed++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake("bp");
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_no_ghost out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_gapped;
    int lat;
    for (int g = 0; g <= 2; g += 2) begin
      for (int j = 0; j < 3; j++) begin
        beat(1, 2, 1, 1, 3, 0, 0, 0, -5);
        repeat (g) @(posedge clk);
      end
      wait_out(lat);
      check_res(g == 0 ? "contig" : "gapped", lat, g == 0 ? 3 : 1, 16'd4, 1'b0);
      handshake(g == 0 ? "contig" : "gapped");
    end
  endtask

  task automatic test_mid_reset;
    int bad;
    beat(100, 100, 100, 100, 4, 0, 0, 0, 0);
    beat(100, 100, 100, 100, 4, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL mid_reset_quiet bad_cycles=%0d required 0", bad);
    else passed++;
    test_single("post_reset");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_rounding();
    test_saturation();
    test_backpressure();
    test_gapped();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
